muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle over WIDTH cycles, registered busy/done/result.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;

    logic [CNT_W-1:0] count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   acc;

    logic [WIDTH-1:0] lo_next;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // One iteration step. Multiply: acc = running high half, lo = multiplier
    // shifting out LSB first while product bits shift in. Divide: acc = partial
    // remainder (WIDTH+1 bits), lo = dividend shifting out MSB first while
    // quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, acc[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (op_q[1]) begin
            acc_next = div_ge ? div_diff : div_shift;
            lo_next  = {lo[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {1'b0, mul_sum[WIDTH:1]};
            lo_next  = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (!flush && (count == CNT_W'(WIDTH - 1))) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Operand latch, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            op_q   <= '0;
            opnd   <= '0;
            lo     <= '0;
            acc    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                op_q  <= op;
                opnd  <= op[1] ? b : a;
                lo    <= op[1] ? a : b;
                acc   <= '0;
                count <= '0;
            end else if ((state == RUN) && !flush) begin
                acc   <= acc_next;
                lo    <= lo_next;
                count <= count + CNT_W'(1);
            end
            // High product and remainder live in acc; low product and quotient in lo.
            if (last) begin
                result <= op_q[0] ? acc_next[WIDTH-1:0] : lo_next;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations compared
// against a plain-arithmetic reference, plus start-ignore, flush and reset cases.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int fails   = 0;
    logic [31:0] held = 32'd0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        logic [63:0] p;
        p = 64'(ma) * 64'(mb);
        case (mop)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (mb == 32'd0) ? 32'hFFFF_FFFF : ma / mb;
            default: return (mb == 32'd0) ? ma : ma % mb;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: plain op; 1: start re-pulsed at E5 and in DONE; 2: flush at E10; 3: reset at E20
    task automatic run_op(input logic [1:0] top, input logic [31:0] ta, input logic [31:0] tb,
                          input int mode);
        logic [31:0] exp;
        exp = model(top, ta, tb);
        @(negedge clk);
        op = top; a = ta; b = tb; start = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        check("busy_after_e0", 32'(busy), 32'd1);
        check("done_after_e0", 32'(done), 32'd0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            if (mode == 1 && (k == 5 || k == 33)) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            end
            if (mode == 2 && k == 10) flush = 1'b1;
            if (mode == 3 && k == 20) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_result", result, 32'd0);
                held = 32'd0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (mode == 2 && k >= 10) begin
                check("flush_busy", 32'(busy), 32'd0);
                check("flush_done", 32'(done), 32'd0);
                if (k == 10 || k == 32) check("flush_result_held", result, held);
            end else if (k < 32) begin
                if (k == 5 || k == 31) begin
                    check("busy_run", 32'(busy), 32'd1);
                    check("done_run", 32'(done), 32'd0);
                end
            end else if (k == 32) begin
                check("done_e32", 32'(done), 32'd1);
                check("busy_e32", 32'(busy), 32'd0);
                check("result_e32", result, exp);
                held = exp;
            end else begin
                check("done_e33", 32'(done), 32'd0);
                check("busy_e33", 32'(busy), 32'd0);
                check("result_hold_e33", result, held);
            end
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (mode == 1) begin
            @(posedge clk); #1;
            check("idle_after_ignored_start", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd0, 32'd7, 32'd6, 0);
        run_op(2'd1, 32'd7, 32'd6, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'd100, 32'd7, 0);
        run_op(2'd3, 32'd100, 32'd7, 0);
        run_op(2'd2, 32'h8000_0000, 32'd1, 0);
        run_op(2'd2, 32'h1234, 32'd0, 0);
        run_op(2'd3, 32'h1234, 32'd0, 0);

        // flush and start together in IDLE: stays idle
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("flush_start_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("flush_start_idle_busy2", 32'(busy), 32'd0);
        check("flush_start_result", result, held);

        run_op(2'd0, 32'd1234567, 32'd89, 1);
        run_op(2'd2, 32'hDEAD_BEEF, 32'd3, 2);
        run_op(2'd1, 32'hCAFE_F00D, 32'h1234_5678, 3);
        run_op(2'd3, 32'hFEDC_BA98, 32'd1000, 0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
